amber_csr_unit: RTL and testbench

// - Responder side of amber's CSR access path: services CSRRD/CSRWR from the execute stage and owns CSR state.
// - Holds STATUS (kernel-mode bit), 48-bit CYCLE/INSTRET counters and a general 24-bit CSR array (u_regcsr successor).
// - Flags illegal accesses (RO write, user-mode access to privileged range) to the trap logic.

---
 rtl/amber_pkg.sv | 46 ++++
 rtl/amber_csr_counter48.sv | 37 +++
 rtl/amber_csr_unit.sv | 124 ++++++++++++
 tb/tb_amber_csr_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/amber_pkg.sv
// Shared constants and decode helper for the amber CSR unit: widths,
// CSR map, privilege boundary and STATUS layout.
package amber_pkg;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 2 * DATA_W;

    localparam logic [ADDR_W-1:0] PRIV_BASE      = 12'hC00;
    localparam logic [ADDR_W-1:0] CSR_STATUS     = 12'h000;
    localparam logic [ADDR_W-1:0] CSR_CYCLE_LO   = 12'h001;
    localparam logic [ADDR_W-1:0] CSR_CYCLE_HI   = 12'h002;
    localparam logic [ADDR_W-1:0] CSR_INSTRET_LO = 12'h003;
    localparam logic [ADDR_W-1:0] CSR_INSTRET_HI = 12'h004;

    localparam int                STATUS_KMODE = 0;
    localparam logic [DATA_W-1:0] STATUS_RST   = 24'h000001;

    typedef enum logic [2:0] {
        SEL_STATUS,
        SEL_CYCLE_LO,
        SEL_CYCLE_HI,
        SEL_INSTRET_LO,
        SEL_INSTRET_HI,
        SEL_ARRAY
    } csr_sel_e;

    function automatic csr_sel_e csr_decode(input logic [ADDR_W-1:0] addr);
        csr_sel_e sel;
        case (addr)
            CSR_STATUS:     sel = SEL_STATUS;
            CSR_CYCLE_LO:   sel = SEL_CYCLE_LO;
            CSR_CYCLE_HI:   sel = SEL_CYCLE_HI;
            CSR_INSTRET_LO: sel = SEL_INSTRET_LO;
            CSR_INSTRET_HI: sel = SEL_INSTRET_HI;
            default:        sel = SEL_ARRAY;
        endcase
        return sel;
    endfunction

    // STATUS and the upper address range are reserved for kernel mode.
    function automatic logic csr_is_priv(input logic [ADDR_W-1:0] addr);
        return (addr == CSR_STATUS) || (addr >= PRIV_BASE);
    endfunction

endpackage

// File: rtl/amber_csr_counter48.sv
// 48-bit free-running counter exposed as a live low word and a high word
// snapshot captured whenever the low word is read.
module amber_csr_counter48
    import amber_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              snap_en,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi_snap
);

    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] snap;

    // Snapshot takes the pre-increment high half so LO/HI form one coherent value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
            snap  <= '0;
        end else begin
            if (inc) begin
                count <= count + 1'b1;
            end
            if (snap_en) begin
                snap <= count[CNT_W-1:DATA_W];
            end
        end
    end

    assign lo      = count[DATA_W-1:0];
    assign hi_snap = snap;

endmodule

// File: rtl/amber_csr_unit.sv
// CSR responder for the amber execute stage: STATUS/KMODE, CYCLE and INSTRET
// counters, general CSR array, and illegal-access fault reporting.
module amber_csr_unit
    import amber_pkg::*;
#(
    parameter logic [CNT_W-1:0] CYCLE_INIT = '0
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_rd_en,
    input  logic [ADDR_W-1:0] iw_rd_addr,
    output logic [DATA_W-1:0] ow_rd_data,
    output logic              ow_rd_valid,
    input  logic              iw_wr_en,
    input  logic [ADDR_W-1:0] iw_wr_addr,
    input  logic [DATA_W-1:0] iw_wr_data,
    input  logic              iw_retire,
    input  logic              iw_trap_enter,
    input  logic              iw_trap_ret,
    output logic              ow_kmode,
    output logic              ow_fault,
    output logic [ADDR_W-1:0] ow_fault_addr
);

    logic [DATA_W-1:0] csr_mem [0:(1<<ADDR_W)-1];

    csr_sel_e          rd_sel;
    csr_sel_e          wr_sel;
    logic              kmode;
    logic              rd_fault;
    logic              wr_fault;
    logic              rd_ok;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] cycle_lo;
    logic [DATA_W-1:0] cycle_hi;
    logic [DATA_W-1:0] instret_lo;
    logic [DATA_W-1:0] instret_hi;

    assign rd_sel = csr_decode(iw_rd_addr);
    assign wr_sel = csr_decode(iw_wr_addr);

    // Privilege uses the pre-edge KMODE; counter words are never writable.
    assign rd_fault = iw_rd_en && !kmode && csr_is_priv(iw_rd_addr);
    assign wr_fault = iw_wr_en &&
                      ((wr_sel inside {SEL_CYCLE_LO, SEL_CYCLE_HI, SEL_INSTRET_LO, SEL_INSTRET_HI}) ||
                       (!kmode && csr_is_priv(iw_wr_addr)));
    assign rd_ok    = iw_rd_en && !rd_fault;
    assign wr_ok    = iw_wr_en && !wr_fault;

    amber_csr_counter48 #(
        .RST_VAL (CYCLE_INIT)
    ) u_cycle (
        .clk     (iw_clk),
        .rst     (iw_rst),
        .inc     (1'b1),
        .snap_en (rd_ok && (rd_sel == SEL_CYCLE_LO)),
        .lo      (cycle_lo),
        .hi_snap (cycle_hi)
    );

    amber_csr_counter48 #(
        .RST_VAL ('0)
    ) u_instret (
        .clk     (iw_clk),
        .rst     (iw_rst),
        .inc     (iw_retire),
        .snap_en (rd_ok && (rd_sel == SEL_INSTRET_LO)),
        .lo      (instret_lo),
        .hi_snap (instret_hi)
    );

    always_comb begin
        rd_mux = '0;
        if (!rd_fault) begin
            case (rd_sel)
                SEL_STATUS:     rd_mux = {{(DATA_W-1){1'b0}}, kmode};
                SEL_CYCLE_LO:   rd_mux = cycle_lo;
                SEL_CYCLE_HI:   rd_mux = cycle_hi;
                SEL_INSTRET_LO: rd_mux = instret_lo;
                SEL_INSTRET_HI: rd_mux = instret_hi;
                default:        rd_mux = csr_mem[iw_rd_addr];
            endcase
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            kmode         <= STATUS_RST[STATUS_KMODE];
            ow_rd_data    <= '0;
            ow_rd_valid   <= 1'b0;
            ow_fault      <= 1'b0;
            ow_fault_addr <= '0;
        end else begin
            ow_rd_valid <= iw_rd_en;
            if (iw_rd_en) begin
                ow_rd_data <= rd_mux;
            end
            ow_fault <= rd_fault || wr_fault;
            if (wr_fault) begin
                ow_fault_addr <= iw_wr_addr;
            end else if (rd_fault) begin
                ow_fault_addr <= iw_rd_addr;
            end
            // Trap events take precedence over a software STATUS write.
            if (iw_trap_enter) begin
                kmode <= 1'b1;
            end else if (iw_trap_ret) begin
                kmode <= 1'b0;
            end else if (wr_ok && (wr_sel == SEL_STATUS)) begin
                kmode <= iw_wr_data[STATUS_KMODE];
            end
        end
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst && wr_ok && (wr_sel == SEL_ARRAY)) begin
            csr_mem[iw_wr_addr] <= iw_wr_data;
        end
    end

    assign ow_kmode = kmode;

endmodule

// File: tb/tb_amber_csr_unit.sv
// Directed bench for amber_csr_unit; a second instance starts CYCLE near the
// 24-bit boundary to exercise the LO/HI carry and snapshot path.
module tb_amber_csr_unit;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [23:0] rd_data;
  logic        rd_valid;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [23:0] wr_data;
  logic        retire;
  logic        trap_enter;
  logic        trap_ret;
  logic        kmode;
  logic        fault;
  logic [11:0] fault_addr;

  logic [23:0] w_rd_data;
  logic        w_rd_valid;
  logic        w_kmode;
  logic        w_fault;
  logic [11:0] w_fault_addr;

  localparam logic [47:0] W_INIT = 48'h000000_FFFF00;

  int checks = 0;
  int errors = 0;

  logic [38:0] exp_q[$];
  logic [38:0] wexp_q[$];

  logic [47:0] cyc_a = '0;
  logic [47:0] cyc_w = '0;
  logic [47:0] ins_a = '0;
  logic [23:0] snap_ca = '0;
  logic [23:0] snap_cw = '0;
  logic [23:0] snap_i = '0;
  logic        km = 1'b1;

  amber_csr_unit dut (
    .iw_clk        (clk),
    .iw_rst        (rst),
    .iw_rd_en      (rd_en),
    .iw_rd_addr    (rd_addr),
    .ow_rd_data    (rd_data),
    .ow_rd_valid   (rd_valid),
    .iw_wr_en      (wr_en),
    .iw_wr_addr    (wr_addr),
    .iw_wr_data    (wr_data),
    .iw_retire     (retire),
    .iw_trap_enter (trap_enter),
    .iw_trap_ret   (trap_ret),
    .ow_kmode      (kmode),
    .ow_fault      (fault),
    .ow_fault_addr (fault_addr)
  );

  amber_csr_unit #(.CYCLE_INIT(W_INIT)) dut_w (
    .iw_clk        (clk),
    .iw_rst        (rst),
    .iw_rd_en      (rd_en),
    .iw_rd_addr    (rd_addr),
    .ow_rd_data    (w_rd_data),
    .ow_rd_valid   (w_rd_valid),
    .iw_wr_en      (wr_en),
    .iw_wr_addr    (wr_addr),
    .iw_wr_data    (wr_data),
    .iw_retire     (retire),
    .iw_trap_enter (trap_enter),
    .iw_trap_ret   (trap_ret),
    .ow_kmode      (w_kmode),
    .ow_fault      (w_fault),
    .ow_fault_addr (w_fault_addr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference counters, advanced on the same edges as the DUT
  always @(posedge clk) begin
    cyc_a <= rst ? 48'h0 : cyc_a + 48'h1;
    cyc_w <= rst ? W_INIT : cyc_w + 48'h1;
    ins_a <= rst ? 48'h0 : ins_a + {47'h0, retire};
  end

  function automatic logic [38:0] pack(input logic k, input logic v, input logic [23:0] d,
                                       input logic f, input logic [11:0] fa);
    return {k, v, v ? d : 24'h0, f, f ? fa : 12'h0};
  endfunction

  // driver: one request cycle, expected outputs queued, compared #1 after the edge
  task automatic step(input logic r, input logic [11:0] ra, input logic w, input logic [11:0] wa,
                      input logic [23:0] wd, input logic [23:0] ed, input logic [23:0] edw,
                      input logic ef, input logic [11:0] efa, input string tag);
    logic        nk;
    logic [38:0] got;
    logic [38:0] want;
    rd_en   = r;
    rd_addr = ra;
    wr_en   = w;
    wr_addr = wa;
    wr_data = wd;
    if (rst) nk = 1'b1;
    else if (trap_enter) nk = 1'b1;
    else if (trap_ret) nk = 1'b0;
    else if (w && wa == 12'h000 && km) nk = wd[0];
    else nk = km;
    exp_q.push_back(pack(nk, r && !rst, ed, ef && !rst, efa));
    wexp_q.push_back(pack(nk, r && !rst, edw, ef && !rst, efa));
    if (rst) begin
      snap_ca = '0;
      snap_cw = '0;
      snap_i  = '0;
    end
    @(posedge clk);
    #1;
    km = nk;
    rd_en = 1'b0; wr_en = 1'b0; retire = 1'b0;
    trap_enter = 1'b0; trap_ret = 1'b0; rst = 1'b0;
    want = exp_q.pop_front();
    got  = pack(kmode, rd_valid, rd_data, fault, fault_addr);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
    want = wexp_q.pop_front();
    got  = pack(w_kmode, w_rd_valid, w_rd_data, w_fault, w_fault_addr);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s_w: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic rd(input logic [11:0] a, input logic [23:0] ed, input string tag);
    step(1'b1, a, 1'b0, 12'h0, 24'h0, ed, ed, 1'b0, 12'h0, tag);
  endtask

  task automatic wr(input logic [11:0] a, input logic [23:0] d, input string tag);
    step(1'b0, 12'h0, 1'b1, a, d, 24'h0, 24'h0, 1'b0, 12'h0, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 12'h0, 1'b0, 12'h0, 24'h0, 24'h0, 24'h0, 1'b0, 12'h0, tag);
  endtask

  task automatic rd_cyc_lo(input string tag);
    logic [23:0] ea;
    logic [23:0] ew;
    ea = cyc_a[23:0];
    ew = cyc_w[23:0];
    snap_ca = cyc_a[47:24];
    snap_cw = cyc_w[47:24];
    step(1'b1, 12'h001, 1'b0, 12'h0, 24'h0, ea, ew, 1'b0, 12'h0, tag);
  endtask

  task automatic rd_cyc_hi(input string tag);
    step(1'b1, 12'h002, 1'b0, 12'h0, 24'h0, snap_ca, snap_cw, 1'b0, 12'h0, tag);
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    retire = 1'b0; trap_enter = 1'b0; trap_ret = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checks++;
    assert ({kmode, rd_valid, rd_data, fault, fault_addr} === {1'b1, 1'b0, 24'h0, 1'b0, 12'h0}) else begin
      errors++;
      $error("FAIL reset: got %h expected %h", {kmode, rd_valid, rd_data, fault, fault_addr},
             {1'b1, 1'b0, 24'h0, 1'b0, 12'h0});
    end
    checks++;
    assert ({w_kmode, w_rd_valid, w_rd_data, w_fault, w_fault_addr} === {1'b1, 1'b0, 24'h0, 1'b0, 12'h0}) else begin
      errors++;
      $error("FAIL reset_w: got %h expected %h", {w_kmode, w_rd_valid, w_rd_data, w_fault, w_fault_addr},
             {1'b1, 1'b0, 24'h0, 1'b0, 12'h0});
    end

    rd_cyc_hi("hi_no_lo");
    wr(12'h321, 24'h000ACE, "wr_321");
    rd(12'h321, 24'h000ACE, "rd_321");
    rd(12'h000, 24'h000001, "rd_status");
    wr(12'h050, 24'h000111, "wr_050");
    step(1'b1, 12'h050, 1'b1, 12'h050, 24'h000222, 24'h000111, 24'h000111, 1'b0, 12'h0, "rdwr_050");
    rd(12'h050, 24'h000222, "rd_050_new");
    wr(12'hC10, 24'h0ABCDE, "wr_c10_k");

    step(1'b0, 12'h0, 1'b1, 12'h001, 24'h000555, 24'h0, 24'h0, 1'b1, 12'h001, "wr_cyc_lo");
    step(1'b0, 12'h0, 1'b1, 12'h004, 24'h000555, 24'h0, 24'h0, 1'b1, 12'h004, "wr_ins_hi");
    rd_cyc_lo("cyc_lo_a");
    for (int i = 0; i < 5; i++) idle("idle");
    rd_cyc_lo("cyc_lo_b");
    rd_cyc_hi("cyc_hi_b");

    trap_ret = 1'b1;
    idle("trap_ret");
    step(1'b1, 12'h000, 1'b0, 12'h0, 24'h0, 24'h0, 24'h0, 1'b1, 12'h000, "u_rd_status");
    step(1'b0, 12'h0, 1'b1, 12'hC10, 24'h123456, 24'h0, 24'h0, 1'b1, 12'hC10, "u_wr_c10");
    rd(12'h321, 24'h000ACE, "u_rd_321");
    step(1'b1, 12'hC10, 1'b1, 12'hC20, 24'h000777, 24'h0, 24'h0, 1'b1, 12'hC20, "u_both_fault");
    step(1'b0, 12'h0, 1'b1, 12'h000, 24'h000001, 24'h0, 24'h0, 1'b1, 12'h000, "u_wr_status");
    trap_enter = 1'b1;
    trap_ret   = 1'b1;
    idle("enter_ret");
    rd(12'hC10, 24'h0ABCDE, "rd_c10_old");
    trap_enter = 1'b1;
    wr(12'h000, 24'h000000, "trap_over_wr");
    wr(12'h000, 24'hFFFFFE, "wr_status_0");
    trap_enter = 1'b1;
    idle("trap_enter");
    wr(12'h000, 24'hFFFFFF, "wr_status_1");
    rd(12'h000, 24'h000001, "rd_status_mask");

    for (int i = 0; i < 3; i++) begin
      retire = 1'b1;
      idle("retire");
    end
    snap_i = ins_a[47:24];
    rd(12'h003, ins_a[23:0], "ins_lo");
    rd(12'h004, snap_i, "ins_hi");

    begin
      int n = 0;
      while (cyc_w != 48'h000000_FFFFFF && n < 2000) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (cyc_w != 48'h000000_FFFFFF) begin
        errors++;
        $display("FAIL wrap_wait: got %h expected %h", cyc_w, 48'h000000_FFFFFF);
      end
    end
    rd_cyc_lo("wrap_lo_0");
    rd_cyc_hi("wrap_hi_0");
    rd_cyc_lo("wrap_lo_1");
    rd_cyc_hi("wrap_hi_1");

    rst = 1'b1;
    step(1'b1, 12'h050, 1'b1, 12'h050, 24'h000333, 24'h0, 24'h0, 1'b0, 12'h0, "rst_mid");
    rd(12'h050, 24'h000222, "rd_050_post_rst");
    rd_cyc_hi("hi_post_rst");
    rd_cyc_lo("lo_post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
